// File: rtl/if_id_stage_if.sv
// IF/ID boundary bundle: fetch/hazard/debug inputs into the stage and the
// decode-side + fetch-control outputs back out.
interface if_id_stage_if #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // into the stage
  logic [DATA_WIDTH-1:0] instr_in;
  logic [ADDR_BITS-1:0]  next_pc_in;
  logic                  branch_taken;
  logic [ADDR_BITS-1:0]  branch_target;
  logic                  ex_mem_read;
  logic [4:0]            ex_rt;
  logic                  debug_mode;
  logic                  debug_step;
  // out of the stage
  logic                  pc_enable;
  logic                  mux_select;
  logic [ADDR_BITS-1:0]  branch_pc_out;
  logic [DATA_WIDTH-1:0] id_instr;
  logic [ADDR_BITS-1:0]  id_next_pc;
  logic                  id_valid;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic [4:0]            id_rd;
  logic                  bubble;
  logic                  halted;
  logic [31:0]           cycle_count;
  logic [31:0]           stall_count;

  // master: fetch/hazard/debug side driving the stage
  modport master (
    output instr_in, next_pc_in, branch_taken, branch_target,
           ex_mem_read, ex_rt, debug_mode, debug_step,
    input  pc_enable, mux_select, branch_pc_out, id_instr, id_next_pc,
           id_valid, id_rs, id_rt, id_rd, bubble, halted,
           cycle_count, stall_count
  );

  // slave: the IF/ID stage itself
  modport slave (
    input  instr_in, next_pc_in, branch_taken, branch_target,
           ex_mem_read, ex_rt, debug_mode, debug_step,
    output pc_enable, mux_select, branch_pc_out, id_instr, id_next_pc,
           id_valid, id_rs, id_rt, id_rd, bubble, halted,
           cycle_count, stall_count
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush, halt detection
// and single-step gating. Fetch control (pc_enable/mux_select) is combinational
// so a redirect or stall reaches the PC in the same cycle.
module if_id_stage #(
  parameter int unsigned           ADDR_BITS  = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = {DATA_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = {DATA_WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  if_id_stage_if.slave  bus
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e                state_q;
  logic                  step_q;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [31:0]           cyc_q, cyc_d;
  logic [31:0]           stall_q, stall_d;

  logic step_pulse, en, hazard, haltd;
  logic [4:0] rs, rt;

  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  // one advance per rising edge of debug_step while single-stepping
  assign step_pulse = bus.debug_step & ~step_q;
  assign en         = (state_q == S_RUN) & (~bus.debug_mode | step_pulse);
  // rt is compared even for I-type: a false stall is harmless, a miss is not
  assign hazard     = valid_q & bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == rs) | (bus.ex_rt == rt));
  assign haltd      = valid_q & (instr_q == HALT_INSTR);

  // fetch control: branch beats halt beats hazard; idle cycles hold fetch and bubble ID/EX
  assign bus.mux_select = en & bus.branch_taken;
  assign bus.pc_enable  = en & (bus.branch_taken | (~haltd & ~hazard));
  assign bus.bubble     = ~en | (~bus.branch_taken & ~haltd & hazard);

  assign bus.branch_pc_out = bus.branch_target;
  assign bus.id_instr      = instr_q;
  assign bus.id_next_pc    = pc_q;
  assign bus.id_valid      = valid_q;
  assign bus.id_rs         = rs;
  assign bus.id_rt         = rt;
  assign bus.id_rd         = instr_q[15:11];
  assign bus.halted        = (state_q == S_HALT);
  assign bus.cycle_count   = cyc_q;
  assign bus.stall_count   = stall_q;

  // next-state for the IF/ID latch and counters; nothing moves without en
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (en) begin
      cyc_d = cyc_q + 32'd1;
      if (bus.branch_taken) begin
        instr_d = NOP_INSTR;
        pc_d    = '0;
        valid_d = 1'b0;
      end else if (!haltd) begin
        if (hazard) begin
          stall_d = stall_q + 32'd1;
        end else begin
          instr_d = bus.instr_in;
          pc_d    = bus.next_pc_in;
          valid_d = 1'b1;
        end
      end
    end
  end

  // run/halt FSM plus pipeline registers; halt is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      step_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      step_q  <= bus.debug_step;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      if (en && haltd && !bus.branch_taken) state_q <= S_HALT;
    end
  end

endmodule
